fpu_arbiter: RTL and testbench

Round-robin scheduler that shares one `FPU_TOP` instance (divide / square root) between `N_REQ` requesters. It accepts operand requests over a valid/ready handshake and drives the FPU's `start`/`ready` protocol. It returns each result on a single tagged response channel, together with a cycle count and an error flag. It sits between the client blocks and `FPU_TOP`; only one operation is in flight at a time.

---
 rtl/fpu_arbiter_pkg.sv | 19 +
 rtl/fpu_arbiter_rr.sv | 31 +++
 rtl/fpu_arbiter.sv | 143 ++++++++++++++
 tb/tb_fpu_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arbiter_pkg.sv
// Shared constants and FSM encoding for the FPU round-robin scheduler.
package fpu_arbiter_pkg;
  localparam int REG_SIZE = 32;
  localparam int OP_BITS  = 2;
  localparam int SQRT_BIT = 0;

  typedef enum logic [2:0] {
    FA_IDLE      = 3'd0,
    FA_ISSUE     = 3'd1,
    FA_WAIT_LOW  = 3'd2,
    FA_WAIT_HIGH = 3'd3,
    FA_RESP      = 3'd4
  } fa_state_e;

  // Cyclic successor of 'last' at distance k within n requesters.
  function automatic int rr_pos(int last, int k, int n);
    return (last + k) % n;
  endfunction
endpackage

// File: rtl/fpu_arbiter_rr.sv
// Combinational round-robin picker: first requester after 'last', cyclically.
module rr_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic          w_found;
  logic [IW-1:0] w_c;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int k = 1; k <= N; k++) begin
      w_c = IW'(rr_pos(int'(last), k, N));
      if (en && !w_found && req[w_c]) begin
        w_found    = 1'b1;
        grant[w_c] = 1'b1;
        idx        = w_c;
      end
    end
  end
endmodule

// File: rtl/fpu_arbiter.sv
// Shares one divide/sqrt FPU between N_REQ clients; one operation in flight,
// results returned on a tagged response channel with cycle count and error flag.
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int REG_W        = REG_SIZE,
  parameter  int OP_W         = OP_BITS,
  parameter  int START_CYCLES = 2,
  parameter  int TIMEOUT      = 64,
  parameter  int CNT_W        = 8,
  localparam int ID_W         = $clog2(N_REQ)
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*REG_W-1:0]  req_a,
  input  logic [N_REQ*REG_W-1:0]  req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [REG_W-1:0]        rsp_res,
  output logic                    rsp_err,
  output logic [CNT_W-1:0]        rsp_cycles,
  output logic                    fpu_start,
  output logic [OP_W-1:0]         fpu_op,
  output logic [REG_W-1:0]        fpu_a,
  output logic [REG_W-1:0]        fpu_b,
  input  logic [REG_W-1:0]        fpu_res,
  input  logic                    fpu_ready
);
  localparam int PH_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  fa_state_e        r_state;
  logic [ID_W-1:0]  r_last, r_id;
  logic [OP_W-1:0]  r_op;
  logic [REG_W-1:0] r_a, r_b, r_res;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [PH_W-1:0]  r_ph;

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_gidx;
  logic             w_hs;
  logic [OP_W-1:0]  w_op;
  logic [REG_W-1:0] w_a, w_b;
  logic             w_busy;

  // Gate with rst so req_ready reads 0 while reset is held.
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .last  (r_last),
    .en    (r_state == FA_IDLE && !rst),
    .grant (w_grant),
    .idx   (w_gidx)
  );

  assign w_hs   = |w_grant;
  assign w_op   = req_op[w_gidx*OP_W +: OP_W];
  assign w_a    = req_a[w_gidx*REG_W +: REG_W];
  assign w_b    = req_b[w_gidx*REG_W +: REG_W];
  assign w_busy = (r_state == FA_ISSUE) || (r_state == FA_WAIT_LOW) ||
                  (r_state == FA_WAIT_HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FA_IDLE;
      r_last  <= ID_W'(N_REQ-1);
      r_id    <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_ph    <= '0;
    end else begin
      if (w_busy && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        FA_IDLE: if (w_hs) begin
          r_op    <= w_op;
          r_a     <= w_a;
          r_b     <= w_op[SQRT_BIT] ? '0 : w_b;
          r_id    <= w_gidx;
          r_last  <= w_gidx;
          r_cnt   <= '0;
          r_err   <= 1'b0;
          r_ph    <= '0;
          r_state <= FA_ISSUE;
        end
        FA_ISSUE: begin
          if (r_ph == PH_W'(START_CYCLES-1)) begin
            r_ph    <= '0;
            r_state <= FA_WAIT_LOW;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        FA_WAIT_LOW: begin
          if (!fpu_ready) begin
            r_ph    <= '0;
            r_state <= FA_WAIT_HIGH;
          end else if (r_ph == PH_W'(TIMEOUT-1)) begin
            r_err   <= 1'b1;
            r_res   <= '0;
            r_state <= FA_RESP;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        FA_WAIT_HIGH: begin
          if (fpu_ready) begin
            r_res   <= fpu_res;
            r_state <= FA_RESP;
          end else if (r_ph == PH_W'(TIMEOUT-1)) begin
            r_err   <= 1'b1;
            r_res   <= '0;
            r_state <= FA_RESP;
          end else begin
            r_ph <= r_ph + 1'b1;
          end
        end
        FA_RESP: if (rsp_ready) r_state <= FA_IDLE;
        default: r_state <= FA_IDLE;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign fpu_start  = (r_state == FA_ISSUE);
  assign fpu_op     = r_op;
  assign fpu_a      = r_a;
  assign fpu_b      = r_b;
  assign rsp_valid  = (r_state == FA_RESP);
  assign rsp_id     = r_id;
  assign rsp_res    = r_res;
  assign rsp_err    = r_err;
  assign rsp_cycles = r_cnt;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: a latency-programmable FPU stand-in plus a rotation/latency reference model.
module tb_fpu_arbiter;
  localparam int N = 4, RW = 32, OW = 2, SC = 2, TO = 64, CW = 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_op = '0;
  logic [N*RW-1:0] req_a = '0, req_b = '0;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [RW-1:0]   rsp_res;
  logic            rsp_err;
  logic [CW-1:0]   rsp_cycles;
  logic            fpu_start;
  logic [OW-1:0]   fpu_op;
  logic [RW-1:0]   fpu_a, fpu_b, fpu_res;
  logic            fpu_ready;

  always #5 clk = ~clk;

  fpu_arbiter #(.N_REQ(N), .REG_W(RW), .OP_W(OW), .START_CYCLES(SC),
                .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .rsp_cycles(rsp_cycles),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_res(fpu_res), .fpu_ready(fpu_ready));

  int checks = 0, errors = 0;
  int m_last = N-1;

  // FPU stand-in: ready drops stub_d cycles after start is seen, rises stub_h later.
  int stub_d = 1, stub_h = 1;
  bit hang_hi = 1'b0, hang_lo = 1'b0;
  int stub_ph, stub_cnt;
  logic [OW-1:0] cap_op;
  logic [RW-1:0] cap_a, cap_b;

  function automatic logic [RW-1:0] fpu_model(logic [OW-1:0] op, logic [RW-1:0] a, logic [RW-1:0] b);
    if (op[0]) begin
      if (a == 32'h41100000) return 32'h40400000;
      return {a[15:0], a[31:16]} ^ 32'h5a5a0001;
    end
    if (a == 32'h40800000 && b == 32'h40000000) return 32'h40000000;
    return a ^ {b[7:0], b[31:8]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_ready <= 1'b1; fpu_res <= '0; stub_ph <= 0; stub_cnt <= 0;
    end else if (rsp_valid) begin
      fpu_ready <= 1'b1; stub_ph <= 0;
    end else begin
      case (stub_ph)
        0: if (fpu_start && !hang_hi) begin
          stub_ph <= 1; stub_cnt <= 1; cap_op <= fpu_op; cap_a <= fpu_a; cap_b <= fpu_b;
        end
        1: if (stub_cnt >= stub_d) begin
          fpu_ready <= 1'b0; stub_ph <= 2; stub_cnt <= 1;
        end else stub_cnt <= stub_cnt + 1;
        2: if (!hang_lo) begin
          if (stub_cnt >= stub_h) begin
            fpu_ready <= 1'b1; fpu_res <= fpu_model(cap_op, cap_a, cap_b); stub_ph <= 3;
          end else stub_cnt <= stub_cnt + 1;
        end
        default: ;
      endcase
    end
  end

  // Reference rotation: first valid requester after the last grant.
  function automatic int exp_grant(logic [N-1:0] v, int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (v[c[IW-1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(int i, logic [OW-1:0] op, logic [RW-1:0] a, logic [RW-1:0] b);
    req_op[i*OW +: OW] = op; req_a[i*RW +: RW] = a; req_b[i*RW +: RW] = b;
  endtask

  task automatic wait_grant(output int g, output bit ok);
    g = -1; ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      #1;
      if (req_ready != '0) begin ok = 1'b1; g = $clog2(req_ready); end
      else @(negedge clk);
    end
  endtask

  // Entered on the first ISSUE cycle; n counts cycles until rsp_valid.
  task automatic wait_rsp(output int n, output int n_start, output logic [RW-1:0] b_or);
    n = 0; n_start = int'(fpu_start); b_or = fpu_b;
    while (!rsp_valid && n < 400) begin
      @(negedge clk); n++;
      if (!rsp_valid) begin n_start += int'(fpu_start); b_or |= fpu_b; end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, rsp_cycles, fpu_start, fpu_op, fpu_a, fpu_b} !== '0) begin
      errors++; $display("FAIL reset_outputs ready=%b rsp_valid=%b fpu_start=%b exp all zero", req_ready, rsp_valid, fpu_start);
    end
    req_valid = '0;
    @(negedge clk); rst = 1'b0; m_last = N-1;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, fpu_start} !== '0) begin
      errors++; $display("FAIL reset_idle ready=%b rsp_valid=%b fpu_start=%b exp 0", req_ready, rsp_valid, fpu_start);
    end
  endtask

  task automatic test_single_div();
    int g, eg, n, ns; bit ok; logic [RW-1:0] bor;
    stub_d = 2; stub_h = 5;
    set_req(1, 2'b00, 32'h40800000, 32'h40000000); req_valid = 4'b0010;
    wait_grant(g, ok); eg = exp_grant(req_valid, m_last);
    checks++;
    if (!ok || req_ready !== 4'(1 << eg)) begin errors++; $display("FAIL div_grant got=%b exp=%b", req_ready, 4'(1 << eg)); end
    m_last = eg;
    @(negedge clk); req_valid = '0;
    checks++;
    if (fpu_start !== 1'b1) begin errors++; $display("FAIL div_start_latency got=%b exp=1", fpu_start); end
    wait_rsp(n, ns, bor);
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, rsp_err} !== {1'b1, 2'd1, 32'h40000000, 1'b0}) begin
      errors++; $display("FAIL div_rsp valid=%b id=%0d res=%h err=%b exp 1/1/40000000/0", rsp_valid, rsp_id, rsp_res, rsp_err);
    end
    checks++;
    if (rsp_cycles !== CW'(SC + 2 + 5) || n != SC + 2 + 5 || rsp_cycles > 40) begin
      errors++; $display("FAIL div_cycles got=%0d lat=%0d exp=%0d", rsp_cycles, n, SC + 7);
    end
    checks++;
    if (ns != SC) begin errors++; $display("FAIL div_start_len got=%0d exp=%0d", ns, SC); end
    checks++;
    if ({cap_op, cap_a, cap_b} !== {2'b00, 32'h40800000, 32'h40000000}) begin
      errors++; $display("FAIL div_operands op=%b a=%h b=%h", cap_op, cap_a, cap_b);
    end
    take_rsp();
  endtask

  task automatic test_single_sqrt();
    int g, eg, n, ns; bit ok; logic [RW-1:0] bor;
    stub_d = 1; stub_h = 4;
    set_req(0, 2'b01, 32'h41100000, 32'hFFFFFFFF); req_valid = 4'b0001;
    wait_grant(g, ok); eg = exp_grant(req_valid, m_last);
    checks++;
    if (!ok || req_ready !== 4'(1 << eg)) begin errors++; $display("FAIL sqrt_grant got=%b exp=%b", req_ready, 4'(1 << eg)); end
    m_last = eg;
    @(negedge clk); req_valid = '0;
    wait_rsp(n, ns, bor);
    checks++;
    if (bor !== '0 || cap_b !== '0) begin errors++; $display("FAIL sqrt_fpu_b got=%h exp=0", bor | cap_b); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_res, rsp_err} !== {1'b1, 2'd0, 32'h40400000, 1'b0}) begin
      errors++; $display("FAIL sqrt_rsp valid=%b id=%0d res=%h err=%b exp 1/0/40400000/0", rsp_valid, rsp_id, rsp_res, rsp_err);
    end
    take_rsp();
  endtask

  task automatic test_fairness();
    int g, n, ns; bit ok; logic [RW-1:0] bor;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0; m_last = N-1;
    for (int i = 0; i < N; i++) set_req(i, 2'($urandom), $urandom, $urandom);
    req_valid = '1; stub_d = 1; stub_h = 2;
    for (int i = 0; i < 8; i++) begin
      wait_grant(g, ok);
      checks++;
      if (!ok || req_ready !== 4'(1 << (i % N))) begin errors++; $display("FAIL fair_grant op=%0d got=%b exp=%b", i, req_ready, 4'(1 << (i % N))); end
      m_last = i % N;
      @(negedge clk);
      wait_rsp(n, ns, bor);
      checks++;
      if (!rsp_valid || rsp_id !== IW'(i % N)) begin errors++; $display("FAIL fair_id op=%0d got=%0d exp=%0d", i, rsp_id, i % N); end
      take_rsp();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout(bit stuck_high);
    int g, eg, n, ns, exp_n; bit ok; logic [RW-1:0] bor;
    hang_hi = stuck_high; hang_lo = !stuck_high; stub_d = 1;
    exp_n = stuck_high ? SC + TO : SC + 1 + TO;
    set_req(3, 2'b00, $urandom, $urandom); req_valid = 4'b1000;
    wait_grant(g, ok); eg = exp_grant(req_valid, m_last);
    checks++;
    if (!ok || req_ready !== 4'(1 << eg)) begin errors++; $display("FAIL tmo_grant got=%b exp=%b", req_ready, 4'(1 << eg)); end
    m_last = eg;
    @(negedge clk); req_valid = '0;
    wait_rsp(n, ns, bor);
    checks++;
    if (n != exp_n) begin errors++; $display("FAIL tmo_latency hi=%0d got=%0d exp=%0d", stuck_high, n, exp_n); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_res, rsp_cycles} !== {1'b1, 1'b1, 32'h0, CW'(exp_n)}) begin
      errors++; $display("FAIL tmo_rsp hi=%0d err=%b res=%h cyc=%0d exp 1/0/%0d", stuck_high, rsp_err, rsp_res, rsp_cycles, exp_n);
    end
    take_rsp();
    hang_hi = 1'b0; hang_lo = 1'b0;
  endtask

  task automatic test_backpressure();
    int g, n, ns; bit ok, unstable, leaked; logic [RW-1:0] bor;
    logic [IW+RW+1+CW-1:0] snap;
    stub_d = 1; stub_h = 3;
    set_req(1, 2'b00, $urandom, $urandom); req_valid = 4'b0010;
    wait_grant(g, ok); m_last = exp_grant(req_valid, m_last);
    @(negedge clk); req_valid = '0;
    wait_rsp(n, ns, bor);
    snap = {rsp_id, rsp_res, rsp_err, rsp_cycles};
    set_req(2, 2'b01, $urandom, $urandom); req_valid = 4'b0100;
    unstable = 1'b0; leaked = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || {rsp_id, rsp_res, rsp_err, rsp_cycles} !== snap) unstable = 1'b1;
      if (req_ready !== '0) leaked = 1'b1;
    end
    checks++;
    if (unstable) begin errors++; $display("FAIL bp_stable got=changed exp=held id=%0d res=%h", rsp_id, rsp_res); end
    checks++;
    if (leaked) begin errors++; $display("FAIL bp_no_grant got=grant exp=none"); end
    take_rsp();
    checks++;
    if (req_ready !== 4'(1 << exp_grant(req_valid, m_last))) begin errors++; $display("FAIL bp_regrant got=%b exp=0100", req_ready); end
    m_last = 2;
    @(negedge clk); req_valid = '0;
    wait_rsp(n, ns, bor);
    checks++;
    if (!rsp_valid || rsp_id !== 2'd2) begin errors++; $display("FAIL bp_id got=%0d exp=2", rsp_id); end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    int g, n, ns; bit ok; logic [RW-1:0] bor;
    hang_lo = 1'b1; stub_d = 1;
    set_req(1, 2'b00, $urandom, $urandom); req_valid = 4'b0010;
    wait_grant(g, ok); m_last = 1;
    @(negedge clk); req_valid = '0;
    repeat (6) @(negedge clk);
    req_valid = '1; rst = 1'b1; #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_err, rsp_cycles, fpu_start, fpu_op, fpu_a, fpu_b} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs ready=%b rsp_valid=%b fpu_start=%b exp all zero", req_ready, rsp_valid, fpu_start);
    end
    hang_lo = 1'b0; m_last = N-1;
    @(negedge clk); rst = 1'b0;
    wait_grant(g, ok);
    checks++;
    if (!ok || rsp_valid !== 1'b0 || req_ready !== 4'(1 << exp_grant(req_valid, m_last))) begin
      errors++; $display("FAIL rst_mid_regrant got=%b rsp_valid=%b exp=0001/0", req_ready, rsp_valid);
    end
    m_last = 0;
    @(negedge clk); req_valid = '0;
    wait_rsp(n, ns, bor);
    checks++;
    if (!rsp_valid || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp id=%0d err=%b exp=0/0", rsp_id, rsp_err); end
    take_rsp();
  endtask

  task automatic test_random(int n_ops);
    int g, eg, n, ns, exp_cyc; bit ok; logic [RW-1:0] bor, ea, eb, er; logic [OW-1:0] eop;
    for (int it = 0; it < n_ops; it++) begin
      for (int i = 0; i < N; i++) set_req(i, 2'($urandom), $urandom, $urandom);
      req_valid = 4'($urandom_range(1, 15));
      stub_d = $urandom_range(1, 6); stub_h = $urandom_range(1, 10);
      wait_grant(g, ok); eg = exp_grant(req_valid, m_last);
      checks++;
      if (!ok || req_ready !== 4'(1 << eg)) begin errors++; $display("FAIL rnd_grant it=%0d got=%b exp=%b", it, req_ready, 4'(1 << eg)); end
      eop = req_op[eg*OW +: OW]; ea = req_a[eg*RW +: RW];
      eb = eop[0] ? '0 : req_b[eg*RW +: RW];
      er = fpu_model(eop, ea, eb); exp_cyc = SC + stub_d + stub_h; m_last = eg;
      @(negedge clk); req_valid = '0;
      wait_rsp(n, ns, bor);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_res, rsp_err, rsp_cycles} !== {1'b1, IW'(eg), er, 1'b0, CW'(exp_cyc)}) begin
        errors++; $display("FAIL rnd_rsp it=%0d id=%0d res=%h err=%b cyc=%0d exp %0d/%h/0/%0d", it, rsp_id, rsp_res, rsp_err, rsp_cycles, eg, er, exp_cyc);
      end
      checks++;
      if ({cap_op, cap_a, cap_b} !== {eop, ea, eb}) begin
        errors++; $display("FAIL rnd_operands it=%0d got=%b/%h/%h exp=%b/%h/%h", it, cap_op, cap_a, cap_b, eop, ea, eb);
      end
      take_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_single_div();
    test_single_sqrt();
    test_fairness();
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_backpressure();
    test_reset_mid();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
